// File: rtl/cart_responder.sv
// Cartridge-bus ROM responder: latches a 32-bit address from the multiplexed AD bus,
// fetches big-endian words from a memory port and serves them halfword by halfword.
module cart_responder #(
  parameter logic [31:0] ROM_BASE      = 32'h1000_0000,
  parameter int          ROM_SIZE_LOG2 = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cart_ad_i,
  output logic [15:0] cart_ad_o,
  output logic        cart_ad_oe,
  input  logic        cart_rd,
  input  logic        cart_alel,
  input  logic        cart_aleh,
  output logic [31:0] mem_addr_o,
  output logic        mem_req_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic        underrun_o
);

  typedef enum logic [2:0] {IDLE, ADDR_LO, FETCH, SERVE, IGNORE} state_t;

  state_t      state;
  logic [2:0]  rd_sync, alel_sync, aleh_sync;
  logic [15:0] ad_r;
  logic [31:0] addr, word;
  logic        abort;

  // [0],[1] form the synchronizer; [2] is the previous synced value for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_sync   <= 3'b111;
      alel_sync <= 3'b000;
      aleh_sync <= 3'b000;
      ad_r      <= 16'h0000;
    end else begin
      rd_sync   <= {rd_sync[1:0], cart_rd};
      alel_sync <= {alel_sync[1:0], cart_alel};
      aleh_sync <= {aleh_sync[1:0], cart_aleh};
      ad_r      <= cart_ad_i;
    end
  end

  logic rd_rise, rd_fall, alel_fall, aleh_rise, aleh_fall;
  assign rd_rise   =  rd_sync[1]   & ~rd_sync[2];
  assign rd_fall   = ~rd_sync[1]   &  rd_sync[2];
  assign alel_fall = ~alel_sync[1] &  alel_sync[2];
  assign aleh_rise =  aleh_sync[1] & ~aleh_sync[2];
  assign aleh_fall = ~aleh_sync[1] &  aleh_sync[2];

  function automatic logic in_win(input logic [31:0] a);
    logic [31:0] off;
    off = a - ROM_BASE;
    return (off >> ROM_SIZE_LOG2) == 32'd0;
  endfunction

  logic [31:0] addr_inc, addr_lo, addr_eff;
  assign addr_inc = addr + 32'd2;
  assign addr_lo  = {addr[31:16], ad_r[15:1], 1'b0};
  // address as it will be after this cycle when a strobe completes during a fetch
  assign addr_eff = (rd_rise && !abort) ? addr_inc : addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr       <= 32'h0;
      word       <= 32'h0;
      abort      <= 1'b0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= 32'h0;
      cart_ad_o  <= 16'h0;
      cart_ad_oe <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      underrun_o <= 1'b0;
      cart_ad_oe <= ((state == SERVE) || (state == FETCH && !abort)) && !rd_sync[1] && !aleh_rise;
      cart_ad_o  <= (state == SERVE) ? (addr[1] ? word[15:0] : word[31:16]) : 16'h0000;
      case (state)
        IDLE: begin
          if (aleh_fall) begin
            addr[31:16] <= ad_r;
            state       <= ADDR_LO;
          end
        end
        ADDR_LO: begin
          if (aleh_rise) state <= IDLE;
          else if (alel_fall) begin
            addr  <= addr_lo;
            state <= in_win(addr_lo) ? FETCH : IGNORE;
          end
        end
        FETCH: begin
          if (rd_rise && !abort) addr <= addr_inc;
          if (rd_fall && !abort && !aleh_rise) underrun_o <= 1'b1;
          if (mem_req_o) begin
            if (aleh_rise) abort <= 1'b1;
            if (mem_ack_i) begin
              mem_req_o <= 1'b0;
              if (abort || aleh_rise) begin
                abort <= 1'b0;
                state <= IDLE;
              end else if (!in_win(addr_eff)) state <= IGNORE;
              else if (addr_eff[31:2] == mem_addr_o[31:2]) begin
                word  <= mem_data_i;
                state <= SERVE;
              end
              // otherwise the strobe moved past this word: stay and refetch
            end
          end else if (aleh_rise) state <= IDLE;
          else if (!in_win(addr_eff)) state <= IGNORE;
          else begin
            mem_req_o  <= 1'b1;
            mem_addr_o <= {addr_eff[31:2], 2'b00};
          end
        end
        SERVE: begin
          if (aleh_rise) state <= IDLE;
          else if (rd_rise) begin
            addr <= addr_inc;
            if (!in_win(addr_inc)) state <= IGNORE;
            else if (!addr_inc[1]) state <= FETCH;
          end
        end
        IGNORE: begin
          if (aleh_rise) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cart_responder.sv
// Bench for cart_responder: cartridge-bus master, delayed-ack memory and a
// transaction-level model of which halfwords and fetches each address cycle yields.
module tb_cart_responder;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          LOG2 = 26;

  logic        clk = 1'b0, reset;
  logic [15:0] cart_ad_i, cart_ad_o;
  logic        cart_ad_oe, cart_rd, cart_alel, cart_aleh;
  logic [31:0] mem_addr_o, mem_data_i;
  logic        mem_req_o, mem_ack_i, underrun_o;

  cart_responder #(.ROM_BASE(BASE), .ROM_SIZE_LOG2(LOG2)) dut (
    .clk(clk), .reset(reset), .cart_ad_i(cart_ad_i), .cart_ad_o(cart_ad_o),
    .cart_ad_oe(cart_ad_oe), .cart_rd(cart_rd), .cart_alel(cart_alel),
    .cart_aleh(cart_aleh), .mem_addr_o(mem_addr_o), .mem_req_o(mem_req_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i), .underrun_o(underrun_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  logic [31:0] mem_key = 32'h0;
  int          mem_delay = 2;
  logic [31:0] flog [0:255];
  int          fcnt = 0, und_cnt = 0, viol = 0;

  // memory contents: word address xor a per-scenario key
  function automatic logic [31:0] mword(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ mem_key;
  endfunction

  function automatic bit win(input logic [31:0] a);
    longint x, lo, hi;
    x  = a;
    lo = BASE;
    hi = lo + (longint'(1) << LOG2);
    return (x >= lo) && (x < hi);
  endfunction

  // memory responder: logs each request, acks after mem_delay cycles, flags protocol slips
  initial begin
    int cnt; bit pend; logic [31:0] cur;
    cnt = 0; pend = 0; cur = 0; mem_ack_i = 0; mem_data_i = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cnt = 0; pend = 0; mem_ack_i = 0;
      end else if (mem_ack_i) begin
        mem_ack_i = 0; pend = 0; cnt = 0;
      end else if (mem_req_o) begin
        if (!pend) begin
          pend = 1; cur = mem_addr_o;
          if (fcnt < 256) flog[fcnt] = mem_addr_o;
          fcnt++;
        end else if (mem_addr_o !== cur) viol++;
        cnt++;
        if (cnt >= mem_delay) begin
          mem_ack_i = 1; mem_data_i = mword(cur);
        end
      end else if (pend) begin
        viol++; pend = 0; cnt = 0;
      end
    end
  end

  always @(negedge clk) if (underrun_o === 1'b1) und_cnt++;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic addr_phase(input logic [31:0] a, input int hi_cyc);
    cart_aleh = 1; cart_alel = 1; cart_ad_i = a[31:16]; cyc(hi_cyc);
    cart_aleh = 0; cyc(6);
    cart_ad_i = a[15:0]; cyc(4);
    cart_alel = 0; cyc(6);
  endtask

  task automatic strobe(output logic [15:0] ad, output logic oe, input int hi_cyc);
    cart_rd = 0; cyc(8);
    ad = cart_ad_o; oe = cart_ad_oe;
    cart_rd = 1; cyc(hi_cyc);
  endtask

  function automatic logic [15:0] half(input logic [31:0] a);
    logic [31:0] w;
    w = mword(a);
    return a[1] ? w[15:0] : w[31:16];
  endfunction

  task automatic run_scn(input logic [31:0] a0, input int n, input logic [31:0] key,
                         input int dly, input string tag);
    logic [31:0] a, exp_f[$];
    logic [15:0] ad;
    logic        oe;
    bit          live;
    int          f0, u0;
    mem_key = key; mem_delay = dly; f0 = fcnt; u0 = und_cnt;
    a = {a0[31:1], 1'b0};
    live = win(a);
    if (live) exp_f.push_back({a[31:2], 2'b00});
    addr_phase(a0, 4);
    cyc(10);
    for (int i = 0; i < n; i++) begin
      strobe(ad, oe, 12);
      chk($sformatf("%s oe%0d", tag, i), 32'(oe), 32'(live));
      if (live) chk($sformatf("%s ad%0d", tag, i), 32'(ad), 32'(half(a)));
      a = a + 32'd2;
      if (!win(a)) live = 0;
      if (live && !a[1]) exp_f.push_back(a);
    end
    chk({tag, " nfetch"}, 32'(fcnt - f0), 32'(exp_f.size()));
    for (int i = 0; i < exp_f.size() && i < fcnt - f0; i++)
      chk($sformatf("%s faddr%0d", tag, i), flog[f0 + i], exp_f[i]);
    chk({tag, " underrun"}, 32'(und_cnt - u0), 32'd0);
  endtask

  initial begin
    logic [15:0] ad;
    logic        oe;
    logic [31:0] a0, key;
    int          f0, u0;
    reset = 1; cart_rd = 1; cart_alel = 0; cart_aleh = 0; cart_ad_i = 16'h0;
    cyc(3);
    chk("rst oe", 32'(cart_ad_oe), 32'd0);
    chk("rst ad", 32'(cart_ad_o), 32'd0);
    chk("rst req", 32'(mem_req_o), 32'd0);
    chk("rst maddr", mem_addr_o, 32'd0);
    chk("rst und", 32'(underrun_o), 32'd0);
    reset = 0; cyc(4);

    run_scn(32'h1000_0000, 2, 32'h1000_0000 ^ 32'hDEAD_BEEF, 2, "beef");
    run_scn(32'h1000_0002, 3, 32'h0, 2, "unal");
    run_scn(32'h0800_0000, 2, $urandom, 2, "outw");

    // data not ready when the strobe arrives
    key = $urandom; mem_key = key; mem_delay = 40; f0 = fcnt; u0 = und_cnt;
    addr_phase(32'h1000_0000, 4);
    strobe(ad, oe, 12);
    chk("und oe", 32'(oe), 32'd1);
    chk("und ad", 32'(ad), 32'd0);
    cyc(30);
    strobe(ad, oe, 12);
    chk("und next ad", 32'(ad), 32'(half(32'h1000_0002)));
    chk("und pulses", 32'(und_cnt - u0), 32'd1);
    chk("und nfetch", 32'(fcnt - f0), 32'd2);
    chk("und f1", flog[f0 + 1], 32'h1000_0004);
    cyc(45);

    // new address cycle while a fetch is outstanding
    key = $urandom; mem_key = key; mem_delay = 15; f0 = fcnt; u0 = und_cnt;
    addr_phase(32'h1000_0000, 4);
    cyc(6);
    addr_phase(32'h1000_0100, 16);
    cyc(25);
    strobe(ad, oe, 12);
    chk("abort ad0", 32'(ad), 32'(half(32'h1000_0100)));
    strobe(ad, oe, 12);
    chk("abort ad1", 32'(ad), 32'(half(32'h1000_0102)));
    chk("abort oe1", 32'(oe), 32'd1);
    cyc(20);
    chk("abort f0", flog[f0], 32'h1000_0000);
    chk("abort f1", flog[f0 + 1], 32'h1000_0100);
    chk("abort und", 32'(und_cnt - u0), 32'd0);

    // reset while serving with the strobe low
    mem_key = $urandom; mem_delay = 2;
    addr_phase(32'h1000_0000, 4);
    cyc(10);
    cart_rd = 0; cyc(8);
    chk("rsrv pre oe", 32'(cart_ad_oe), 32'd1);
    reset = 1; #1;
    chk("rsrv oe", 32'(cart_ad_oe), 32'd0);
    chk("rsrv req", 32'(mem_req_o), 32'd0);
    @(negedge clk); cyc(1);
    reset = 0; cyc(4);
    cart_rd = 1; cyc(10);
    f0 = fcnt;
    for (int i = 0; i < 2; i++) begin
      strobe(ad, oe, 12);
      chk($sformatf("rsrv post oe%0d", i), 32'(oe), 32'd0);
    end
    chk("rsrv nfetch", 32'(fcnt - f0), 32'd0);

    // reset while a fetch is outstanding
    mem_delay = 30;
    addr_phase(32'h1000_0000, 4);
    cyc(2);
    chk("rfch req pre", 32'(mem_req_o), 32'd1);
    reset = 1; #1;
    chk("rfch req", 32'(mem_req_o), 32'd0);
    cyc(2); reset = 0; cyc(40);
    chk("rfch req post", 32'(mem_req_o), 32'd0);
    chk("rfch oe post", 32'(cart_ad_oe), 32'd0);

    for (int k = 0; k < 14; k++) begin
      case ($urandom_range(0, 3))
        0: a0 = BASE + ($urandom & 32'h03FF_FFFF);
        1: a0 = BASE + (32'd1 << LOG2) - 32'(2 * $urandom_range(1, 6));
        2: a0 = BASE - 32'(2 * $urandom_range(1, 4));
        default: a0 = $urandom;
      endcase
      run_scn(a0, $urandom_range(1, 5), $urandom, $urandom_range(1, 4),
              $sformatf("rnd%0d@%h", k, a0));
    end

    chk("mem protocol", 32'(viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
